// File: rtl/regfile_pkg.sv
// Shared constants and flattened-bus helpers for the pipelined register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_NUM_RD   = 3;
    localparam int unsigned DEF_PC_IDX   = 15;
    localparam int unsigned DEF_LR_IDX   = 14;

    // LSB of field k in a bus made of equal-width fields of width w.
    function automatic int unsigned fieldLsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

    // The PC is not stored, so indices above it shift down by one slot.
    function automatic int unsigned storeSlot(input int unsigned idx, input int unsigned pcIdx);
        return (idx > pcIdx) ? idx - 1 : idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue and write-back bundle between the core and the register file.
interface regfile_scoreboard_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 3
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_used;
    logic [DATA_W-1:0]        pc_val;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_dest;
    logic                     stall;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     link_en;
    logic [DATA_W-1:0]        link_data;
    logic                     write_to_pc;

    modport master (
        output rd_addr, rd_used, pc_val, issue_valid, issue_dest,
        output wb_en, wb_addr, wb_data, link_en, link_data,
        input  rd_data, stall, write_to_pc
    );

    modport slave (
        input  rd_addr, rd_used, pc_val, issue_valid, issue_dest,
        input  wb_en, wb_addr, wb_data, link_en, link_data,
        output rd_data, stall, write_to_pc
    );

endinterface

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: one bit per register, drives the decode stall.
module regfile_scoreboard_sb #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_RD   = 3,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_dest,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    output logic                     stall
);
    import regfile_pkg::*;

    logic [NUM_REGS-1:0] pendingQ;
    logic [NUM_REGS-1:0] pendingD;
    logic                stallComb;

    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic              wbHit;
        stallComb = 1'b0;
        addr      = '0;
        wbHit     = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr  = rd_addr[fieldLsb(k, ADDR_W) +: ADDR_W];
            wbHit = (BYPASS != 0) && wb_en && (wb_addr == addr);
            if (rd_used[k] && pendingQ[addr] && !wbHit) begin
                stallComb = 1'b1;
            end
        end
        // WAW: a second producer may not issue until the first has written back.
        if (issue_valid && pendingQ[issue_dest] && !(wb_en && (wb_addr == issue_dest))) begin
            stallComb = 1'b1;
        end
    end

    assign stall = stallComb;

    // Set is applied after clear so a freshly issued producer keeps its bit.
    always_comb begin
        pendingD = pendingQ;
        if (wb_en) begin
            pendingD[wb_addr] = 1'b0;
        end
        if (issue_valid && !stallComb) begin
            pendingD[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pendingQ <= '0;
        end else begin
            pendingQ <= pendingD;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pipelined register file: N read ports, write-back and link writes, PC substitution,
// optional write-to-read bypass and a pending-write scoreboard for decode stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_RD    = DEF_NUM_RD,
    parameter int unsigned PC_IDX    = DEF_PC_IDX,
    parameter int unsigned LR_IDX    = DEF_LR_IDX,
    parameter int unsigned PC_OFFSET = 8,
    parameter int unsigned BYPASS    = 1
) (
    input logic           clk,
    input logic           reset,
    regfile_scoreboard_if.slave bus
);

    localparam int unsigned       NumSlots = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] PcAddr   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LrAddr   = ADDR_W'(LR_IDX);
    localparam logic [DATA_W-1:0] PcOffset = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0]        regsQ [NumSlots];
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic                     bypassOk;

    function automatic logic [ADDR_W-1:0] slotAddr(input int unsigned slot);
        return ADDR_W'((slot >= PC_IDX) ? slot + 1 : slot);
    endfunction

    // Link write takes priority over a write-back to the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumSlots; i++) begin
                regsQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (bus.link_en && (slotAddr(i) == LrAddr)) begin
                    regsQ[i] <= bus.link_data;
                end else if (bus.wb_en && (bus.wb_addr == slotAddr(i))) begin
                    regsQ[i] <= bus.wb_data;
                end
            end
        end
    end

    // Bypass is suppressed during reset so non-PC reads stay at zero.
    assign bypassOk = (BYPASS != 0) && reset;

    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] slot;
        logic [DATA_W-1:0] val;
        rdData = '0;
        addr   = '0;
        slot   = '0;
        val    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = bus.rd_addr[fieldLsb(k, ADDR_W) +: ADDR_W];
            slot = ADDR_W'(storeSlot(int'(addr), PC_IDX));
            if (addr == PcAddr) begin
                val = bus.pc_val + PcOffset;
            end else if (bypassOk && bus.link_en && (addr == LrAddr)) begin
                val = bus.link_data;
            end else if (bypassOk && bus.wb_en && (addr == bus.wb_addr)) begin
                val = bus.wb_data;
            end else begin
                val = regsQ[slot];
            end
            rdData[fieldLsb(k, DATA_W) +: DATA_W] = val;
        end
    end

    assign bus.rd_data     = rdData;
    assign bus.write_to_pc = bus.wb_en && (bus.wb_addr == PcAddr);

    regfile_scoreboard_sb #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (bus.rd_addr),
        .rd_used     (bus.rd_used),
        .issue_valid (bus.issue_valid),
        .issue_dest  (bus.issue_dest),
        .wb_en       (bus.wb_en),
        .wb_addr     (bus.wb_addr),
        .stall       (bus.stall)
    );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle ARM register file for the pipelined core.
- Provides N combinational read ports and one write-back port, with PC-read substitution, a dedicated link-register write and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard that drives the decode-stage stall.
- Sits between decode/issue and write-back; the PC register itself is owned by the fetch unit.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, architectural register count (power of two)
- ADDR_W, 4, register index width, equal to log2(NUM_REGS)
- NUM_RD, 3, number of read ports (Rn, Rm, Rs)
- PC_IDX, 15, index whose reads return the PC
- LR_IDX, 14, link register index
- PC_OFFSET, 8, added to pc_val on PC reads
- BYPASS, 1, 1 = read of a register being written this cycle returns the write data

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = reset asserted)
- rd_addr  in  NUM_RD*ADDR_W  flattened read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  flattened read data, same packing
- rd_used  in  NUM_RD  port k operand is needed by the instruction in decode
- pc_val  in  DATA_W  current PC from fetch
- issue_valid  in  1  decode issues an instruction that writes a register
- issue_dest  in  ADDR_W  destination of the issuing instruction
- stall  out  1  hazard: decode must hold
- wb_en  in  1  write-back valid
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back data
- link_en  in  1  write link_data to LR_IDX
- link_data  in  DATA_W  return address (fetch supplies PC-4)
- write_to_pc  out  1  wb_en && wb_addr==PC_IDX; fetch loads wb_data

Behaviour:
- Reset (reset==0, asynchronous): all storage registers cleared to 0 and all pending bits cleared. While reset is held, rd_data is 0 for non-PC ports, stall is 0 and write_to_pc follows its combinational definition. Reset overrides any write in the same cycle.
- Storage: NUM_REGS-1 entries; PC_IDX is not stored. wb_en to PC_IDX updates no storage and only raises write_to_pc.
- Writes occur on the rising edge of clk. When wb_en and link_en both target LR_IDX, link_data wins. A write to any other register proceeds in parallel with the link write.
- Read port k, combinational, zero latency:
  - if addr==PC_IDX: pc_val+PC_OFFSET, truncated modulo 2^DATA_W;
  - else if BYPASS and link_en and addr==LR_IDX: link_data;
  - else if BYPASS and wb_en and addr==wb_addr: wb_data;
  - else: the stored value.
  - With BYPASS=0, a read sees the new value one cycle after the write.
- Scoreboard: one pending bit per register, PC_IDX included.
  - Set on the clock edge when issue_valid && !stall, at issue_dest.
  - Cleared on the clock edge when wb_en, at wb_addr.
  - link_en does not touch pending bits.
  - Same edge, same register, set and clear both active: set wins, because a new producer has been issued.
  - wb_en to a non-pending register is legal; the clear is a no-op.
- stall = OR over k of (rd_used[k] && pending[rd_addr[k]] && !(BYPASS && wb_en && wb_addr==rd_addr[k])), OR (issue_valid && pending[issue_dest] && !(wb_en && wb_addr==issue_dest)). The second term is the WAW check.
  - A read of PC_IDX stalls only if PC_IDX is pending.
- Holding issue_valid while stall=1 has no effect on state.
- No internal counters overflow. Scoreboard depth is one outstanding write per register by construction.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, PC_IDX and LR_IDX constants, and a function pack/unpack for the flattened port buses.
- One natural sub-module: regfile_scoreboard_sb, which holds the pending bits, set/clear logic and stall generation. It takes the rd_addr, rd_used, issue and wb signals plus the BYPASS parameter. The data array and read muxes stay in the top level.

Test Plan:
- Reset: hold reset=0 with wb_en=1, wb_addr=3, wb_data=32'h55 → after release all ports read 0, stall=0, R3 is still 0.
- Write/read with BYPASS=1: wb_en=1, wb_addr=8, wb_data=32'hAAAAAAAA, rd_addr0=8 → rd_data0=AAAAAAAA in the same cycle and after the edge. With BYPASS=0 → old value 0 in that cycle, AAAAAAAA the next cycle.
- PC read and PC write: pc_val=32'h100, rd_addr1=15 → rd_data1=32'h108. wb_en=1, wb_addr=15 → write_to_pc=1 and no stored register changes.
- Link collision: link_en=1, link_data=32'h1FC with wb_en=1, wb_addr=14, wb_data=32'hDEAD → R14=32'h1FC. In the same edge wb_addr=2 also writes R2 correctly.
- RAW stall: issue_valid, issue_dest=5 → next cycle rd_addr0=5, rd_used0=1 gives stall=1. wb_en to 5 that cycle → stall=0 (bypass) and pending[5] clears.
- WAW and set-wins: pending[6]=1, issue_dest=6 → stall=1 and no state change. Then wb_en to 6 together with issue_dest=6 → stall=0 and pending[6] remains 1 after the edge.
